vector_reader: RTL and testbench

Read-side master for the single-port block RAM. Given a base address and word count, it drives the RAM address port and streams the returned words onto a valid/ready output, which feeds the multiplier datapath. It absorbs the RAM's one-cycle registered read latency and tolerates downstream backpressure without losing or duplicating words. It never writes the RAM.

---
 rtl/vector_reader.sv | 204 ++++++++++++++++++++
 tb/tb_vector_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_reader.sv
// vector_reader
//
// Read-side master for a single-port block RAM with a one-cycle registered
// read. A transfer is requested with a base address and a word count. The
// reader walks the RAM addresses in order and streams the returned words onto
// a valid/ready output. A small two-entry FIFO takes up the RAM latency and
// lets the consumer stall without losing or repeating words. The RAM is never
// written.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous reset, active low (0 = in reset)
//   start            single-cycle transfer request, sampled only when idle
//   base_addr        first word address, captured with start
//   length           number of words, captured with start (0 is legal)
//   busy             high from the accepted start until the done cycle ends
//   done             one-cycle pulse at the end of a transfer
//   mem_addr         RAM address
//   mem_write_enable RAM write enable, tied low
//   mem_data_in      RAM write data, tied low
//   mem_reset        RAM reset, tied low
//   mem_data_out     RAM read data, valid the cycle after the address is sampled
//   out_data         stream data (FIFO head)
//   out_valid        stream valid (FIFO non-empty)
//   out_ready        stream ready from the consumer
//   out_last         high with the final word of the transfer

module vector_reader #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_reset,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issueLeft_q, issueLeft_d;
  logic [LEN_WIDTH-1:0]  wordCnt_q, wordCnt_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] fifoMem_q [2];
  logic                  wrPtr_q;
  logic                  rdPtr_q;
  logic [1:0]            fifoCount_q;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic [2:0]            occupancy;

  // The reader only ever reads, so the write side of the RAM is tied off.
  assign mem_write_enable = 1'b0;
  assign mem_data_in      = '0;
  assign mem_reset        = 1'b0;

  assign mem_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

  assign out_valid = (fifoCount_q != 2'd0);
  assign out_data  = fifoMem_q[rdPtr_q];
  assign out_last  = out_valid && (wordCnt_q == (len_q - LEN_WIDTH'(1)));

  assign pop  = out_valid && out_ready;
  // A read issued last cycle returns its word now; it lands in the FIFO at
  // the coming edge.
  assign push = inflight_q;

  // Words buffered plus the one still in the RAM pipeline. A new read is only
  // issued if, after this cycle's pop, there is guaranteed room for it in the
  // two-entry FIFO when its data arrives. pop implies a non-empty FIFO, so the
  // subtraction cannot underflow.
  assign occupancy = {1'b0, fifoCount_q} + {2'b00, inflight_q};
  assign issue     = (state_q == FETCH) && ((occupancy - {2'b00, pop}) < 3'd2);

  // Next-state and datapath control. A start outside IDLE is simply not
  // looked at, so a second request during a transfer has no effect.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issueLeft_d = issueLeft_q;
    wordCnt_d   = wordCnt_q;
    inflight_d  = issue;

    if (pop) begin
      wordCnt_d = wordCnt_q + LEN_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = length;
          wordCnt_d = '0;
          if (length != '0) begin
            // mem_addr is left alone for an empty transfer.
            addr_d      = base_addr;
            issueLeft_d = length;
            state_d     = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end

      FETCH: begin
        if (issue) begin
          // Address wraps naturally at the top of the address space.
          addr_d      = addr_q + ADDR_WIDTH'(1);
          issueLeft_d = issueLeft_q - LEN_WIDTH'(1);
          if (issueLeft_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (pop && out_last) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transfer bookkeeping registers. Reset abandons any transfer in
  // progress without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issueLeft_q <= '0;
      wordCnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issueLeft_q <= issueLeft_d;
      wordCnt_q   <= wordCnt_d;
      inflight_q  <= inflight_d;
    end
  end

  // Two-entry output FIFO. Push and pop in the same cycle leave the count
  // unchanged; the head register only moves on a pop, so out_data holds still
  // while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      fifoCount_q <= 2'd0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= mem_data_out;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + 2'd1;
        2'b01:   fifoCount_q <= fifoCount_q - 2'd1;
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_reader.sv
// tb_vector_reader
//
// Bench for vector_reader. A behavioural RAM with mem[i] = i[7:0] and a
// one-cycle registered read sits on the memory port. Expected words are queued
// when a transfer is requested and popped as the stream delivers them.

module tb_vector_reader;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int LW = 18;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_write_enable;
  logic [DW-1:0] mem_data_in;
  logic          mem_reset;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW:0]   expQ [$];

  int errors;
  int checks;

  vector_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_data_in      (mem_data_in),
    .mem_reset        (mem_reset),
    .mem_data_out     (mem_data_out),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model
  always @(posedge clk) begin
    mem_data_out <= ram[mem_addr];
  end

  // Drive a one-cycle start (called just after a rising edge) and queue the
  // words the transfer should produce.
  task automatic startTransfer(input logic [AW-1:0] b, input logic [LW-1:0] n);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a = b + i[AW-1:0];
      expQ.push_back({(i == int'(n) - 1), ram[a]});
    end
    start     = 1'b1;
    base_addr = b;
    length    = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got=%b want=0", out_last); end
    checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr got=%h want=0", mem_addr); end
    checks++; if ({mem_write_enable, mem_reset, mem_data_in} !== '0) begin
      errors++; $display("[TB] FAIL reset_ties got we=%b rst=%b din=%h want all 0", mem_write_enable, mem_reset, mem_data_in);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [DW:0] exp;
    int it, firstPop, lastPop, doneAt;
    out_ready = 1'b1;
    firstPop = -1; lastPop = -1; doneAt = -1; it = 0;
    startTransfer(18'h00010, 18'd4);
    while (doneAt < 0 && it < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL basic_extra got data=%h want no word", out_data);
        end else begin
          exp = expQ.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++; $display("[TB] FAIL basic_word got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[DW], exp[DW-1:0]);
          end
        end
        if (firstPop < 0) firstPop = it;
        lastPop = it;
      end
      if (done) doneAt = it;
      @(posedge clk); #1; it++;
    end
    checks++; if (doneAt < 0) begin errors++; $display("[TB] FAIL basic_timeout got no done want done"); end
    checks++; if (firstPop < 0 || firstPop > 3) begin errors++; $display("[TB] FAIL basic_latency got first word at cycle %0d want <=3", firstPop); end
    checks++; if (lastPop - firstPop != 3) begin errors++; $display("[TB] FAIL basic_throughput got span=%0d want 3", lastPop - firstPop); end
    checks++; if (doneAt != lastPop + 1) begin errors++; $display("[TB] FAIL basic_done_time got cycle %0d want %0d", doneAt, lastPop + 1); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL basic_count got %0d words missing want 0", expQ.size()); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_after_done got done=%b busy=%b want 0 0", done, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    logic [DW:0] exp;
    logic [5:0]  pat;
    logic [AW-1:0] issued;
    int it, doneAt, popped, maxOut, outNow;
    pat = 6'b101001;
    it = 0; doneAt = -1; popped = 0; maxOut = 0;
    out_ready = pat[0];
    startTransfer(18'h00010, 18'd4);
    while (doneAt < 0 && it < 200) begin
      @(negedge clk);
      if (busy && !done) begin
        issued = mem_addr - 18'h00010;
        outNow = int'(issued) - popped;
        if (outNow > maxOut) maxOut = outNow;
      end
      if (out_valid && !out_ready && expQ.size() != 0) begin
        checks++;
        if ({out_last, out_data} !== expQ[0]) begin
          errors++; $display("[TB] FAIL stall_hold got last=%b data=%h want last=%b data=%h", out_last, out_data, expQ[0][DW], expQ[0][DW-1:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL stall_extra got data=%h want no word", out_data);
        end else begin
          exp = expQ.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++; $display("[TB] FAIL stall_word got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[DW], exp[DW-1:0]);
          end
        end
        popped++;
      end
      if (done) doneAt = it;
      @(posedge clk); #1; it++;
      out_ready = pat[it % 6];
    end
    checks++; if (doneAt < 0) begin errors++; $display("[TB] FAIL stall_timeout got no done want done"); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL stall_count got %0d words missing want 0", expQ.size()); end
    checks++; if (maxOut > 2) begin errors++; $display("[TB] FAIL stall_outstanding got %0d want <=2", maxOut); end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    logic [DW:0] exp;
    int it, doneAt;
    out_ready = 1'b1;
    it = 0; doneAt = -1;
    startTransfer(18'h3FFFE, 18'd4);
    while (doneAt < 0 && it < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL wrap_extra got data=%h want no word", out_data);
        end else begin
          exp = expQ.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++; $display("[TB] FAIL wrap_word got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (done) doneAt = it;
      @(posedge clk); #1; it++;
    end
    checks++; if (doneAt < 0) begin errors++; $display("[TB] FAIL wrap_timeout got no done want done"); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL wrap_count got %0d words missing want 0", expQ.size()); end
    checks++; if (mem_addr !== 18'h00002) begin errors++; $display("[TB] FAIL wrap_addr got %h want 00002", mem_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_length;
    logic [AW-1:0] addrBefore;
    addrBefore = mem_addr;
    out_ready = 1'b1;
    startTransfer(18'h00123, 18'd0);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got=%b want=1", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid got=%b want=0", out_valid); end
    checks++; if (mem_addr !== addrBefore) begin errors++; $display("[TB] FAIL zero_addr got=%h want=%h", mem_addr, addrBefore); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_after got done=%b busy=%b valid=%b want 0 0 0", done, busy, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    logic [DW:0] exp;
    int it, doneAt;
    out_ready = 1'b0;
    startTransfer(18'h00020, 18'd2);
    repeat (5) @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h20) begin
      errors++; $display("[TB] FAIL abort_pre got valid=%b data=%h want 1 20", out_valid, out_data);
    end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_clear got valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
    end
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    it = 0; doneAt = -1;
    startTransfer(18'h00000, 18'd2);
    while (doneAt < 0 && it < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL abort_extra got data=%h want no word", out_data);
        end else begin
          exp = expQ.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++; $display("[TB] FAIL abort_word got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (done) doneAt = it;
      @(posedge clk); #1; it++;
    end
    checks++; if (doneAt < 0) begin errors++; $display("[TB] FAIL abort_timeout got no done want done"); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL abort_count got %0d words missing want 0", expQ.size()); end
  endtask

  task automatic test_start_while_busy;
    logic [DW:0] exp;
    int it, doneAt, strayValid;
    out_ready = 1'b1;
    it = 0; doneAt = -1; strayValid = 0;
    startTransfer(18'h00040, 18'd4);
    while (doneAt < 0 && it < 100) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL busy_start_extra got data=%h want no word", out_data);
        end else begin
          exp = expQ.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++; $display("[TB] FAIL busy_start_word got last=%b data=%h want last=%b data=%h", out_last, out_data, exp[DW], exp[DW-1:0]);
          end
        end
      end
      if (done) doneAt = it;
      @(posedge clk); #1; it++;
      start     = (it == 2);
      base_addr = 18'h00080;
      length    = 18'd3;
    end
    start = 1'b0;
    checks++; if (doneAt < 0) begin errors++; $display("[TB] FAIL busy_start_timeout got no done want done"); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL busy_start_count got %0d words missing want 0", expQ.size()); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid || busy) strayValid++;
    end
    checks++; if (strayValid != 0) begin errors++; $display("[TB] FAIL busy_start_stray got %0d active cycles want 0", strayValid); end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    reset     = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = i[DW-1:0];
    end
    $display("[TB] vector_reader bench starting");
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_length();
    test_reset_abort();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
